result_bank: RTL

Output-side counterpart of the operand memory bank in the 3x3 matrix multiplication accelerator. Captures the 3x3 result matrix from the systolic array one row per strobe. Once all three rows are present, streams the nine elements out serially in row-major order over a valid/ready handshake. Sits between the PE array outputs and the host/readout interface.

---
 rtl/result_pkg.sv | 21 ++
 rtl/result_sat.sv | 26 ++
 rtl/result_bank.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/result_pkg.sv
// Shared constants and helpers for the 3x3 result bank.
// Element storage is row-major: index = N*row + col.
package result_pkg;

    localparam int N          = 3;
    localparam int LAST_IDX   = N * N - 1;
    localparam int IDX_W      = 4;

    localparam int DATA_W_DEF = 4;
    localparam int ACC_W_DEF  = 2 * DATA_W_DEF + 2;
    localparam int OUT_W_DEF  = 8;

    // Two-state controller: collect rows, then stream elements out.
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    function automatic logic [IDX_W-1:0] elem_index(input logic [1:0] row, input int col);
        return IDX_W'(N * int'(row) + col);
    endfunction

endpackage

// File: rtl/result_sat.sv
// ACC_W -> OUT_W element conversion for the streamed output.
// Define RESULT_SAT_EN to clamp at 2^OUT_W-1; otherwise the value is truncated.
module result_sat
    import result_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [ACC_W-1:0] din,
    output logic [OUT_W-1:0] dout
);

    generate
        if (OUT_W >= ACC_W) begin : g_zext
            assign dout = OUT_W'(din);
        end else begin : g_narrow
`ifdef RESULT_SAT_EN
            localparam logic [ACC_W-1:0] MAX_V = {{(ACC_W - OUT_W){1'b0}}, {OUT_W{1'b1}}};
            assign dout = (din > MAX_V) ? {OUT_W{1'b1}} : din[OUT_W-1:0];
`else
            assign dout = din[OUT_W-1:0];
`endif
        end
    endgenerate

endmodule

// File: rtl/result_bank.sv
// Captures the 3x3 result matrix one row per strobe, then streams the nine
// elements row-major over valid/ready. Saturating output when RESULT_SAT_EN is defined.
module result_bank
    import result_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             res_valid,
    input  logic [1:0]       res_row,
    input  logic [ACC_W-1:0] res_in1,
    input  logic [ACC_W-1:0] res_in2,
    input  logic [ACC_W-1:0] res_in3,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] data_out,
    output logic             out_last,
    output logic             frame_done,
    output logic             busy,
    output logic             err
);

    generate
        if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
            $error("result_bank: ACC_W too narrow for DATA_W products");
        end
    endgenerate

    logic [0:0]       state_q, state_d;
    logic [2:0]       rmask_q, rmask_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ACC_W-1:0] mem_q [0:LAST_IDX];
    logic [ACC_W-1:0] mem_d [0:LAST_IDX];
    logic             err_q, err_d;
    logic             frame_done_q, frame_done_d;

    logic             in_stream;
    logic             row_bad;
    logic [2:0]       rmask_new;
    logic [ACC_W-1:0] sel_elem;
    logic [OUT_W-1:0] conv_out;

    assign in_stream = (state_q == ST_STREAM);
    assign row_bad   = res_valid && (res_row == 2'd3);
    assign rmask_new = rmask_q | (3'b001 << res_row);

    // Handshake: an element transfers on a posedge where out_valid && out_ready;
    // data_out is held stable while out_valid is high and out_ready is low.
    always_comb begin
        state_d      = state_q;
        rmask_d      = rmask_q;
        idx_d        = idx_q;
        mem_d        = mem_q;
        err_d        = err_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (res_valid && !row_bad) begin
                    mem_d[elem_index(res_row, 0)] = res_in1;
                    mem_d[elem_index(res_row, 1)] = res_in2;
                    mem_d[elem_index(res_row, 2)] = res_in3;
                    rmask_d = rmask_new;
                    if (rmask_new == 3'b111) begin
                        state_d = ST_STREAM;
                        idx_d   = '0;
                    end
                end
            end
            ST_STREAM: begin
                // Rows cannot be replaced while the frame is being read out.
                if (res_valid) begin
                    err_d = 1'b1;
                end
                if (out_ready) begin
                    if (idx_q == IDX_W'(LAST_IDX)) begin
                        state_d      = ST_IDLE;
                        rmask_d      = '0;
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rmask_d = '0;
                idx_d   = '0;
            end
        endcase

        if (row_bad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q      <= ST_IDLE;
            rmask_q      <= '0;
            idx_q        <= '0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i <= LAST_IDX; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            rmask_q      <= rmask_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i <= LAST_IDX; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    always_comb begin
        sel_elem = '0;
        for (int i = 0; i <= LAST_IDX; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_elem = mem_q[i];
            end
        end
    end

    result_sat #(
        .ACC_W(ACC_W),
        .OUT_W(OUT_W)
    ) u_sat (
        .din (sel_elem),
        .dout(conv_out)
    );

    assign out_valid  = in_stream;
    assign data_out   = in_stream ? conv_out : '0;
    assign out_last   = in_stream && (idx_q == IDX_W'(LAST_IDX));
    assign busy       = in_stream;
    assign err        = err_q;
    assign frame_done = frame_done_q;

endmodule
